// File: rtl/song_pkg.sv
// ============================================================================
// Module  : song_pkg
// Brief   : Shared state encoding and song-ROM field layout for song_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package song_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Default ROM word layout: {half_period[21:0], duration[3:0]}
  localparam int DUR_LSB = 0;
  localparam int DUR_MSB = 3;
  localparam int HP_LSB  = 4;
  localparam int HP_MSB  = 25;

  localparam int END_MARKER_DUR = 0;
  localparam int REST_HP        = 0;

endpackage

`default_nettype wire

// File: rtl/song_sequencer_tone_divider.sv
// ============================================================================
// Module  : tone_divider
// Brief   : Programmable square-wave divider; period is 2*half_period cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_divider #(
  parameter int NOTE_W = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [NOTE_W-1:0] half_period,
  output logic              tone_out
);

  logic [NOTE_W-1:0] cnt_q;
  logic [NOTE_W-1:0] hp_last_q;
  logic              tone_q;
  logic              w_restart;
  logic [NOTE_W-1:0] w_cnt;
  logic              w_tone;

  // A new half-period is treated as counter 0 in the very cycle it appears,
  // so each note starts low and gets a full first half-period.
  assign w_restart = !en || (half_period != hp_last_q);
  assign w_cnt     = w_restart ? '0   : cnt_q;
  assign w_tone    = w_restart ? 1'b0 : tone_q;
  assign tone_out  = w_tone;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      hp_last_q <= '0;
      tone_q    <= 1'b0;
    end else begin
      hp_last_q <= half_period;
      if (!en) begin
        cnt_q  <= '0;
        tone_q <= 1'b0;
      end else if (w_cnt == half_period - 1'b1) begin
        cnt_q  <= '0;
        tone_q <= ~w_tone;
      end else begin
        cnt_q  <= w_cnt + 1'b1;
        tone_q <= w_tone;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/song_sequencer.sv
// ============================================================================
// Module  : song_sequencer
// Brief   : Walks a synchronous song ROM and drives a tone divider per note.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module song_sequencer
  import song_pkg::*;
#(
  parameter int unsigned TEMPO_TICKS = 6250000,
  parameter int unsigned GAP_TICKS   = 500000,
  parameter int          NOTE_W      = HP_MSB - HP_LSB + 1,
  parameter int          DUR_W       = DUR_MSB - DUR_LSB + 1,
  parameter int          ADDR_W      = 5,
  parameter int          SONG_LEN    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic                    busy,
  output logic [ADDR_W-1:0]       note_idx,
  output logic                    audio_out
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
  localparam logic [31:0]       TEMPO_C   = 32'(TEMPO_TICKS);
  localparam logic [31:0]       GAP_C     = 32'(GAP_TICKS);
  localparam logic [31:0]       GAP_LOAD  = GAP_C - 32'd1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [ADDR_W-1:0] idx_q,   idx_d;
  logic [NOTE_W-1:0] hp_q,    hp_d;
  logic [31:0]       timer_q, timer_d;

  logic [DUR_W-1:0]  w_rom_dur;
  logic [NOTE_W-1:0] w_rom_hp;
  logic [31:0]       w_play_load;
  logic              w_tone_en;
  logic              w_tone;

  assign w_rom_dur   = rom_data[DUR_LSB +: DUR_W];
  assign w_rom_hp    = rom_data[DUR_W +: NOTE_W];
  // PLAY and GAP together span dur*TEMPO_TICKS cycles
  assign w_play_load = 32'(w_rom_dur) * TEMPO_C - GAP_C - 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      hp_q    <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      hp_q    <= hp_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    hp_d    = hp_q;
    timer_d = timer_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_FETCH;
            addr_d  = '0;
          end
        end
        S_FETCH: state_d = S_LATCH;
        S_LATCH: begin
          hp_d  = w_rom_hp;
          idx_d = addr_q;
          if (w_rom_dur == DUR_W'(END_MARKER_DUR)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_PLAY;
            timer_d = w_play_load;
          end
        end
        S_PLAY: begin
          if (timer_q == 32'd0) begin
            state_d = S_GAP;
            timer_d = GAP_LOAD;
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
        S_GAP: begin
          if (timer_q == 32'd0) begin
            if (addr_q == LAST_ADDR) begin
              state_d = S_DONE;
            end else begin
              state_d = S_FETCH;
              addr_d  = addr_q + 1'b1;
            end
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
        S_DONE: begin
          if (loop_en) begin
            state_d = S_FETCH;
            addr_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    w_tone_en = (state_q == S_PLAY) && (hp_q != NOTE_W'(REST_HP));
    rom_addr  = addr_q;
    note_idx  = idx_q;
    audio_out = w_tone;
  end

  tone_divider #(
    .NOTE_W (NOTE_W)
  ) u_tone_divider (
    .clk         (clk),
    .reset       (reset),
    .en          (w_tone_en),
    .half_period (hp_q),
    .tone_out    (w_tone)
  );

endmodule

`default_nettype wire

// File: tb/tb_song_sequencer.sv
// ============================================================================
// Module  : tb_song_sequencer
// Brief   : Scoreboard bench; expected per-cycle trace is built from the ROM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_song_sequencer;

  localparam int T   = 10;
  localparam int G   = 2;
  localparam int LEN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [4:0]  rom_addr;
  logic [25:0] rom_data = '0;
  logic        busy;
  logic [4:0]  note_idx;
  logic        audio_out;

  logic [25:0] rom [32];
  logic [11:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_idx   = 0;
  int          m_addr  = 0;

  song_sequencer #(
    .TEMPO_TICKS (T),
    .GAP_TICKS   (G),
    .NOTE_W      (22),
    .DUR_W       (4),
    .ADDR_W      (5),
    .SONG_LEN    (LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy),
    .note_idx  (note_idx),
    .audio_out (audio_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pk(input bit b, input bit a, input int idx, input int addr);
    return {b, a, 5'(idx), 5'(addr)};
  endfunction

  function automatic logic [11:0] observed();
    return {busy, audio_out, note_idx, rom_addr};
  endfunction

  // Expected {busy, audio, note_idx, rom_addr} for every cycle after start
  task automatic gen_song(input int passes);
    int a, h, d, p;
    bit fin;
    a = 0; p = 0; fin = 0;
    while (!fin) begin
      exp_q.push_back(pk(1, 0, m_idx, a));
      exp_q.push_back(pk(1, 0, m_idx, a));
      m_idx = a; m_addr = a;
      h = int'(rom[a][25:4]);
      d = int'(rom[a][3:0]);
      if (d != 0) begin
        for (int k = 0; k < d * T - G; k++)
          exp_q.push_back(pk(1, (h != 0) && (((k / h) % 2) == 1), a, a));
        for (int k = 0; k < G; k++)
          exp_q.push_back(pk(1, 0, a, a));
      end
      if (d == 0 || a == LEN - 1) begin
        exp_q.push_back(pk(1, 0, a, a));
        p++;
        if (p >= passes) fin = 1;
        a = 0;
      end else begin
        a++;
      end
    end
    exp_q.push_back(pk(0, 0, m_idx, m_addr));
  endtask

  // poke_kind: 1 start while busy, 2 stop, 3 reset, 4 clear loop_en
  task automatic run_song(input int passes, input int poke_at, input int poke_kind);
    logic [11:0] e;
    int n;
    n = 0;
    gen_song(passes);
    start = 1'b1;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0; reset = 1'b0;
      n++;
      e = exp_q.pop_front();
      check($sformatf("trace c%0d {busy,aud,idx,addr}", n), 32'(observed()), 32'(e));
      if (n == poke_at) begin
        case (poke_kind)
          1: start = 1'b1;
          2: begin
            stop = 1'b1;
            exp_q.delete();
            m_idx = int'(e[9:5]); m_addr = int'(e[4:0]);
            exp_q.push_back(pk(0, 0, m_idx, m_addr));
          end
          3: begin
            reset = 1'b1;
            exp_q.delete();
            m_idx = 0; m_addr = 0;
            exp_q.push_back(pk(0, 0, 0, 0));
          end
          4: loop_en = 1'b0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    check(tag, 32'(observed()), 32'(pk(0, 0, m_idx, m_addr)));
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = '0;
  endtask

  initial begin
    clear_rom();
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 32'(observed()), 32'd0);
    reset = 1'b0;

    // Two tones then end marker; stray start mid-song must be ignored
    rom[0] = {22'd3, 4'd1};
    rom[1] = {22'd5, 4'd2};
    rom[2] = {22'd0, 4'd0};
    run_song(1, 16, 1);

    start = 1'b1; stop = 1'b1;
    idle_check("start+stop from idle");
    idle_check("idle hold");

    run_song(1, 20, 2);
    run_song(1, 0, 0);

    run_song(1, 6, 3);
    run_song(1, 0, 0);

    // Rest in the middle, fastest tone after it
    clear_rom();
    rom[0] = {22'd3, 4'd1};
    rom[1] = {22'd0, 4'd1};
    rom[2] = {22'd1, 4'd1};
    rom[3] = {22'd0, 4'd0};
    run_song(1, 0, 0);

    // Full-length song looping once, loop_en dropped during second pass
    clear_rom();
    rom[0] = {22'd2, 4'd1};
    rom[1] = {22'd3, 4'd2};
    rom[2] = {22'd1, 4'd1};
    rom[3] = {22'd4, 4'd1};
    loop_en = 1'b1;
    run_song(2, 70, 4);
    idle_check("final idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Note scheduler for the audio tone path. Steps through an external synchronous song ROM, one entry per note.
- Programs a per-note half-period into an internal programmable tone divider, and times each note's duration in tempo units.
- Sits between the board clock and the speaker pin. Replaces the fixed-limit single-tone divider with a sequenced, configurable one.

Parameters:
- TEMPO_TICKS, 6250000, clk cycles per duration unit (1/8 s at 50 MHz).
- GAP_TICKS, 500000, silent articulation cycles at the end of each note. Must be < TEMPO_TICKS.
- NOTE_W, 22, width of the half-period field (clk cycles per audio half-period).
- DUR_W, 4, width of the duration field (tempo units).
- ADDR_W, 5, ROM address width.
- SONG_LEN, 32, number of ROM entries. Must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin the song at entry 0. Ignored while busy.
- stop  in  1  level or pulse: abort playback.
- loop_en  in  1  1 = restart at entry 0 after the song ends.
- rom_addr  out  ADDR_W  song ROM address.
- rom_data  in  NOTE_W+DUR_W  {half_period, duration}. Valid 1 cycle after rom_addr.
- busy  out  1  high in every state except IDLE.
- note_idx  out  ADDR_W  index of the note currently sounding.
- audio_out  out  1  square-wave speaker drive.

Behaviour:
- Reset, synchronous, active-high:
  - state = IDLE; all outputs 0 (rom_addr, busy, note_idx, audio_out); internal counters 0.
  - Reset mid-song takes effect on the next edge.
- FSM states: IDLE, FETCH, LATCH, PLAY, GAP, DONE.
- IDLE:
  - start=1 and stop=0 → FETCH with rom_addr=0, busy=1 on the next cycle.
  - start and stop together: stop wins, stay in IDLE.
- FETCH: one cycle with rom_addr held → LATCH.
- LATCH: capture rom_data into hp_reg and dur_reg; note_idx ← rom_addr.
  - dur_reg==0 is the end marker → DONE.
  - Otherwise → PLAY, load play_cnt = dur*TEMPO_TICKS − GAP_TICKS − 1.
- PLAY:
  - Tone enabled with half-period hp_reg; play_cnt decrements each cycle.
  - At 0 → GAP, load gap_cnt = GAP_TICKS − 1.
- GAP:
  - Tone disabled, audio_out=0.
  - At 0: if rom_addr==SONG_LEN−1 → DONE; else rom_addr+1 → FETCH.
- DONE:
  - loop_en=1 → FETCH with rom_addr=0.
  - Otherwise → IDLE with busy=0.
- Timing: latency from start to first audio-enabled cycle is 3 cycles (FETCH, LATCH, PLAY).
- Note period: each note occupies exactly 2 + dur*TEMPO_TICKS cycles from FETCH to the next FETCH.
- stop=1 in any state → IDLE on the next edge; audio_out=0 the same edge; rom_addr unchanged.
- Rest: hp_reg==0 is a rest. Timing proceeds normally, audio_out is held 0.
- Arithmetic: dur*TEMPO_TICKS is computed in a 32-bit unsigned counter. There is no wrap for DUR_W=4 at the default tempo.
- Tone divider:
  - 0-based counter; audio toggles when counter == hp−1, and the counter clears on the same edge. Output period is 2*hp cycles.
  - Counter and output clear whenever enable=0 or hp changes, so every note starts low with a full half-period.
  - hp==1 toggles every cycle.

Decomposition:
- Shared package song_pkg:
  - FSM state encoding (3-bit localparams).
  - Field slicing constants HP_MSB/HP_LSB and DUR_MSB/DUR_LSB.
  - END_MARKER_DUR = 0 and REST_HP = 0.
- Sub-module tone_divider (clk, reset, en, half_period[NOTE_W], tone_out): a programmable version of the fixed divider.
- The sequencer FSM and duration timers stay in song_sequencer.

Test Plan (TEMPO_TICKS=10, GAP_TICKS=2, SONG_LEN=4, sync-ROM model):
- ROM {hp=3,dur=1},{hp=5,dur=2},{0,0}; pulse start:
  - audio_out toggles every 3 cycles for 8 cycles, then low 2 cycles.
  - Then toggles every 5 cycles for 18 cycles, then low 2 cycles.
  - busy falls 3 cycles after the end marker is fetched.
- Rest entry {hp=0,dur=1}: audio_out stays 0 for the full 12-cycle slot; note_idx advances normally.
- Four non-zero entries, loop_en=1: after entry 3's GAP, rom_addr returns to 0 and busy stays 1.
  - Clear loop_en: the next pass ends in IDLE.
- stop asserted mid-PLAY of entry 1: next cycle busy=0 and audio_out=0.
  - A subsequent start restarts from entry 0.
- start and stop in the same cycle from IDLE: busy stays 0.
  - start pulsed while busy: no restart, note_idx sequence unchanged.
- reset asserted during PLAY: next edge, all outputs 0 and state IDLE.
  - A start after release plays entry 0 with correct timing.
